dp_sequencer: RTL
=================

Name: dp_sequencer

Overview:
Owns the datapath control state register and sequences multi-cycle datapath operations from a decoded instruction.
- Generalises the earlier state-to-control decoder: per-instruction state sequencing, a start/wait handshake, a one-hot register-select output and a parametrised vsel width.
- vsel is always driven to a defined value and never floats.
- Sits between the instruction register and the datapath (register file, A/B/C/status registers, writeback mux).

Parameters:
NUM_SEL, 4, number of writeback mux inputs; vsel width SEL_WIDTH = $clog2(NUM_SEL); legal range >= 2.
SEL_C, 0, vsel code selecting ALU result C.
SEL_IMM, 1, vsel code selecting sign-extended immediate.

Ports:
clk  input  1  rising-edge clock, the only clock.
reset_n  input  1  synchronous, active-low reset.
s  input  1  start request; sampled only in WAIT.
opcode  input  3  instruction opcode; captured on WAIT->DECODE.
op  input  2  ALU/move sub-op; captured with opcode.
w  output  1  1 only in WAIT (ready for next instruction).
write  output  1  register-file write enable.
loada  output  1  A register load.
loadb  output  1  B register load.
loadc  output  1  C register load.
loads  output  1  status register load.
asel  output  1  1 forces the ALU A input to zero.
nsel  output  3  one-hot register select: 100=Rn, 010=Rd, 001=Rm, 000=none.
vsel  output  SEL_WIDTH  writeback mux select; always defined.
illegal  output  1  one-cycle flag for an undecodable instruction.

Behaviour:
- All outputs are Moore-decoded from the registered state and the captured {opcode,op}.
- Outputs not listed for a state are 0. vsel = SEL_C except where stated.
- States: WAIT, DECODE, WRITE_IMM, LOAD_A, LOAD_B, LOAD_C, WRITE_C, LOAD_S.
- Reset (reset_n=0 at a clk edge): state -> WAIT, captured instruction -> 0.
  - Outputs then read w=1, all loads/write/asel/illegal=0, nsel=000, vsel=SEL_C.
  - Reset mid-sequence aborts immediately; no load or write occurs in the cycle after the reset edge.
- WAIT: w=1. On an edge with s=1, capture {opcode,op} and go to DECODE. With s=0, stay in WAIT.
- s is ignored in every state other than WAIT. Changes on opcode/op after capture have no effect.
- DECODE routes by captured instruction:
  - 110/10 MOV imm -> WRITE_IMM
  - 110/00 MOV reg -> LOAD_B
  - 101/00 ADD, 101/01 CMP, 101/10 AND -> LOAD_A
  - 101/11 MVN -> LOAD_B
  - any other combination -> WAIT with illegal=1 during DECODE
- WRITE_IMM: write=1, nsel=100, vsel=SEL_IMM -> WAIT.
- LOAD_A: loada=1, nsel=100 -> LOAD_B.
- LOAD_B: loadb=1, nsel=001 -> LOAD_S for CMP, otherwise LOAD_C.
- LOAD_C: loadc=1; asel=1 for MOV reg and MVN, else 0 -> WRITE_C.
- WRITE_C: write=1, nsel=010, vsel=SEL_C -> WAIT.
- LOAD_S: loads=1 -> WAIT.
- Busy cycles (w=0) per instruction:
  - MOV imm 2
  - MOV reg 4
  - ADD 5
  - AND 5
  - CMP 4
  - MVN 4
  - illegal 1
- s held high continuously starts a new instruction on the first edge after each return to WAIT; back-to-back instructions cost one WAIT cycle each.
- At most one of write/loada/loadb/loadc/loads is high in any cycle. illegal is never high outside DECODE.
- Invariant: the state register never holds an unencoded value. Unused encodings transition to WAIT.

Test Plan:
- reset_n=0 for 2 cycles mid-ADD (in LOAD_B) -> next cycle w=1, loadb=0, nsel=000, vsel=0; no write follows.
- s=1, opcode=110, op=10 -> DECODE, then WRITE_IMM with write=1, nsel=100, vsel=1, then w=1. w low exactly 2 cycles.
- s=1, opcode=101, op=00 -> loada(nsel=100), loadb(nsel=001), loadc(asel=0), write(nsel=010, vsel=0) on consecutive cycles after DECODE. w low 5 cycles.
- opcode=101, op=01 (CMP) -> loada, loadb, loads; write never asserted. w low 4 cycles.
- opcode=101, op=11 (MVN), opcode changed to 110 during LOAD_B -> sequence unaffected, asel=1 in LOAD_C, write in WRITE_C.
- opcode=111, op=00 -> illegal=1 for exactly the DECODE cycle, no load/write, w=1 next cycle. With s held high, the next instruction starts one cycle later.

Source files
------------

// File: rtl/dp_sequencer_if.sv
// Handshake and control bundle between the instruction register,
// the datapath sequencer and the datapath.
interface dp_sequencer_if #(
  parameter int NUM_SEL = 4
) ();
  localparam int SEL_WIDTH = $clog2(NUM_SEL);

  logic                 s;
  logic [2:0]           opcode;
  logic [1:0]           op;
  logic                 w;
  logic                 write;
  logic                 loada;
  logic                 loadb;
  logic                 loadc;
  logic                 loads;
  logic                 asel;
  logic [2:0]           nsel;
  logic [SEL_WIDTH-1:0] vsel;
  logic                 illegal;

  // Instruction side: issues start/opcode, observes control outputs.
  modport master (
    output s, opcode, op,
    input  w, write, loada, loadb, loadc, loads, asel, nsel, vsel, illegal
  );

  // Sequencer side.
  modport slave (
    input  s, opcode, op,
    output w, write, loada, loadb, loadc, loads, asel, nsel, vsel, illegal
  );
endinterface

// File: rtl/dp_sequencer.sv
// Datapath sequencer: owns the control state register and walks each
// decoded instruction through its multi-cycle load/write sequence.
module dp_sequencer #(
  parameter int NUM_SEL = 4,
  parameter int SEL_C   = 0,
  parameter int SEL_IMM = 1
) (
  input logic           clk,
  input logic           reset_n,
  dp_sequencer_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(NUM_SEL);
  localparam logic [SEL_WIDTH-1:0] VSEL_C   = SEL_WIDTH'(SEL_C);
  localparam logic [SEL_WIDTH-1:0] VSEL_IMM = SEL_WIDTH'(SEL_IMM);

  // Captured {opcode, op} encodings.
  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;
  localparam logic [4:0] I_MVN     = 5'b101_11;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_C,
    S_WRITE_C,
    S_LOAD_S
  } state_t;

  state_t               state, state_n;
  logic [4:0]           instr, instr_n;
  logic                 w_n, write_n, loada_n, loadb_n, loadc_n, loads_n;
  logic                 asel_n, illegal_n;
  logic [2:0]           nsel_n;
  logic [SEL_WIDTH-1:0] vsel_n;

  // Next state and instruction capture.
  always_comb begin
    state_n = S_WAIT;
    instr_n = instr;
    case (state)
      S_WAIT: begin
        if (bus.s) begin
          state_n = S_DECODE;
          instr_n = {bus.opcode, bus.op};
        end else begin
          state_n = S_WAIT;
        end
      end
      S_DECODE: begin
        case (instr)
          I_MOV_IMM:             state_n = S_WRITE_IMM;
          I_MOV_REG, I_MVN:      state_n = S_LOAD_B;
          I_ADD, I_CMP, I_AND:   state_n = S_LOAD_A;
          default:               state_n = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_n = S_WAIT;
      S_LOAD_A:    state_n = S_LOAD_B;
      S_LOAD_B:    state_n = (instr == I_CMP) ? S_LOAD_S : S_LOAD_C;
      S_LOAD_C:    state_n = S_WRITE_C;
      S_WRITE_C:   state_n = S_WAIT;
      S_LOAD_S:    state_n = S_WAIT;
      default:     state_n = S_WAIT;
    endcase
  end

  // Moore output decode of the upcoming state, so the output registers
  // line up cycle-for-cycle with the state register.
  always_comb begin
    w_n       = 1'b0;
    write_n   = 1'b0;
    loada_n   = 1'b0;
    loadb_n   = 1'b0;
    loadc_n   = 1'b0;
    loads_n   = 1'b0;
    asel_n    = 1'b0;
    illegal_n = 1'b0;
    nsel_n    = 3'b000;
    vsel_n    = VSEL_C;
    case (state_n)
      S_WAIT:   w_n = 1'b1;
      S_DECODE: illegal_n = !(instr_n inside {I_MOV_IMM, I_MOV_REG, I_ADD,
                                              I_CMP, I_AND, I_MVN});
      S_WRITE_IMM: begin
        write_n = 1'b1;
        nsel_n  = 3'b100;
        vsel_n  = VSEL_IMM;
      end
      S_LOAD_A: begin
        loada_n = 1'b1;
        nsel_n  = 3'b100;
      end
      S_LOAD_B: begin
        loadb_n = 1'b1;
        nsel_n  = 3'b001;
      end
      S_LOAD_C: begin
        loadc_n = 1'b1;
        asel_n  = (instr_n == I_MOV_REG) || (instr_n == I_MVN);
      end
      S_WRITE_C: begin
        write_n = 1'b1;
        nsel_n  = 3'b010;
      end
      S_LOAD_S: loads_n = 1'b1;
      default:  w_n = 1'b0;
    endcase
  end

  // State, captured instruction and registered control outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_WAIT;
      instr       <= '0;
      bus.w       <= 1'b1;
      bus.write   <= 1'b0;
      bus.loada   <= 1'b0;
      bus.loadb   <= 1'b0;
      bus.loadc   <= 1'b0;
      bus.loads   <= 1'b0;
      bus.asel    <= 1'b0;
      bus.illegal <= 1'b0;
      bus.nsel    <= 3'b000;
      bus.vsel    <= VSEL_C;
    end else begin
      state       <= state_n;
      instr       <= instr_n;
      bus.w       <= w_n;
      bus.write   <= write_n;
      bus.loada   <= loada_n;
      bus.loadb   <= loadb_n;
      bus.loadc   <= loadc_n;
      bus.loads   <= loads_n;
      bus.asel    <= asel_n;
      bus.illegal <= illegal_n;
      bus.nsel    <= nsel_n;
      bus.vsel    <= vsel_n;
    end
  end
endmodule
